// File: rtl/addsub_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin add/sub scheduler:
// slot state encoding, operation mode encoding and the signed-overflow rule.
package addsub_rr_scheduler_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Signed overflow from operand/result sign bits; subtraction flips the sign test on b.
    function automatic logic addsub_of(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic mode);
        logic same_s;
        same_s = (mode == MODE_SUB) ? (a_msb != b_msb) : (a_msb == b_msb);
        return same_s & (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_rr_scheduler_if.sv
// Request/response bundle between the datapath clients and the shared adder scheduler.
interface addsub_rr_scheduler_if #(
    parameter int NREQ = 2,
    parameter int W    = 64,
    parameter int IDW  = 3,
    parameter int CNTW = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_mode;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_of;
    logic [CNTW-1:0]   of_count;

    modport master (
        output req_valid, req_a, req_b, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_of, of_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_of, of_count
    );
endinterface

// File: rtl/add_sub_64bit.sv
// Combinational 64-bit adder/subtractor with signed-overflow flag.
module add_sub_64bit
    import addsub_rr_scheduler_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        mode,
    output logic [63:0] result,
    output logic        of
);
    assign result = (mode == MODE_SUB) ? (a - b) : (a + b);
    assign of     = addsub_of(a[63], b[63], result[63], mode);
endmodule

// File: rtl/addsub_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer, wrapping, wins.
module addsub_rr_scheduler_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    // Rotating priority search starting at ptr.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int pos_s;
            pos_s = int'(ptr) + k;
            if (pos_s >= NREQ) begin
                pos_s = pos_s - NREQ;
            end else begin
                pos_s = pos_s;
            end
            if (!any && req[pos_s]) begin
                any          = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = IDW'(pos_s);
            end else begin
                any = any;
            end
        end
    end
endmodule

// File: rtl/addsub_rr_scheduler.sv
// Shares one add_sub_64bit between NREQ requesters with round-robin grant and a
// one-deep registered response slot tagged with the issuing requester id.
module addsub_rr_scheduler
    import addsub_rr_scheduler_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 64,
    parameter int IDW  = 3,
    parameter int CNTW = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    addsub_rr_scheduler_if.slave bus
);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    slot_state_e     state_r, state_nxt_s;
    logic [IDW-1:0]  ptr_r;
    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  gidx_s;
    logic            any_s;
    logic            can_accept_s;
    logic            accept_s;
    logic [W-1:0]    op_a_s, op_b_s, sum_s;
    logic            op_mode_s, of_s;
    logic [IDW-1:0]  rsp_id_r;
    logic [W-1:0]    rsp_result_r;
    logic            rsp_of_r;
    logic [CNTW-1:0] of_count_r;

    addsub_rr_scheduler_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (any_s)
    );

    // rst_n gates ready so nothing is handshaken while held in reset.
    assign can_accept_s   = (state_r == ST_EMPTY) | bus.rsp_ready;
    assign accept_s       = any_s & can_accept_s & rst_n;
    assign bus.req_ready  = grant_s & {NREQ{can_accept_s & rst_n}};
    assign bus.rsp_valid  = (state_r == ST_FULL);
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_of     = rsp_of_r;
    assign bus.of_count   = of_count_r;

    // Operand mux: granted requester's operands, zero when idle.
    always_comb begin
        op_a_s    = '0;
        op_b_s    = '0;
        op_mode_s = MODE_ADD;
        if (accept_s) begin
            op_a_s    = bus.req_a[int'(gidx_s)*W +: W];
            op_b_s    = bus.req_b[int'(gidx_s)*W +: W];
            op_mode_s = bus.req_mode[gidx_s];
        end else begin
            op_mode_s = MODE_ADD;
        end
    end

    add_sub_64bit u_alu (
        .a      (op_a_s),
        .b      (op_b_s),
        .mode   (op_mode_s),
        .result (sum_s),
        .of     (of_s)
    );

    // Slot next-state: a fresh accept always fills; drained slot without accept empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) state_nxt_s = ST_FULL;
                else          state_nxt_s = ST_EMPTY;
            end
            ST_FULL: begin
                if (bus.rsp_ready && !accept_s) state_nxt_s = ST_EMPTY;
                else                            state_nxt_s = ST_FULL;
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_EMPTY;
        else        state_r <= state_nxt_s;
    end

    // Round-robin pointer moves just past the winner on each accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= (gidx_s == IDW'(NREQ-1)) ? '0 : gidx_s + IDW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Response slot payload; held stable until a new accept overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_r     <= '0;
            rsp_result_r <= '0;
            rsp_of_r     <= 1'b0;
        end else if (accept_s) begin
            rsp_id_r     <= gidx_s;
            rsp_result_r <= sum_s;
            rsp_of_r     <= of_s;
        end else begin
            rsp_id_r     <= rsp_id_r;
            rsp_result_r <= rsp_result_r;
            rsp_of_r     <= rsp_of_r;
        end
    end

    // Saturating count of overflowing accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_count_r <= '0;
        end else if (accept_s && of_s && (of_count_r != CNT_MAX)) begin
            of_count_r <= of_count_r + CNTW'(1);
        end else begin
            of_count_r <= of_count_r;
        end
    end

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed-vector bench for addsub_rr_scheduler (NREQ=2, 4-bit overflow counter
// so saturation is reached quickly).
module tb_addsub_rr_scheduler;
    localparam int NREQ = 2;
    localparam int W    = 64;
    localparam int IDW  = 3;
    localparam int CNTW = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    addsub_rr_scheduler_if #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) bus ();

    addsub_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic m);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_mode[i]     = m;
    endtask

    // Single-requester op with immediate drain; checks grant, then the registered response.
    task automatic one_op(input string tag, input int i, input logic [63:0] a, input logic [63:0] b,
                          input logic m, input logic [63:0] exp_r, input logic exp_of,
                          input logic [63:0] exp_cnt);
        set_req(i, a, b, m);
        bus.req_valid = 2'b00;
        bus.req_valid[i] = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(bus.req_ready), 64'(2'b01 << i));
        step();
        bus.req_valid = 2'b00;
        chk({tag, "_vld"}, 64'(bus.rsp_valid), 64'd1);
        chk({tag, "_res"}, bus.rsp_result, exp_r);
        chk({tag, "_of"},  64'(bus.rsp_of), 64'(exp_of));
        chk({tag, "_id"},  64'(bus.rsp_id), 64'(i));
        chk({tag, "_cnt"}, 64'(bus.of_count), exp_cnt);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_mode = 2'b00;
        bus.rsp_ready = 1'b1;
        #2;
        chk("rst_rdy", 64'(bus.req_ready), 64'd0);
        chk("rst_vld", 64'(bus.rsp_valid), 64'd0);
        chk("rst_res", bus.rsp_result, 64'd0);
        chk("rst_cnt", 64'(bus.of_count), 64'd0);
        bus.req_valid = 2'b00;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic add and signed add/sub with overflow.
        one_op("t1", 0, 64'd2811, 64'd1012, 1'b0, 64'd3823, 1'b0, 64'd0);
        one_op("t2a", 1, -64'sd1243, 64'd1234, 1'b0, -64'sd9, 1'b0, 64'd0);
        one_op("t2b", 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 64'd1);
        one_op("t2c", 1, 64'h8000_0000_0000_16B0, 64'd6000, 1'b1, 64'h7FFF_FFFF_FFFF_FF40, 1'b1, 64'd2);

        // Both requesters valid: alternating grants, one response per cycle.
        set_req(0, 64'd1, 64'd1, 1'b0);
        set_req(1, 64'd10, 64'd3, 1'b1);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_rdy", 64'(bus.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            step();
            chk("t3_vld", 64'(bus.rsp_valid), 64'd1);
            chk("t3_id",  64'(bus.rsp_id), 64'(k % 2));
            chk("t3_res", bus.rsp_result, (k % 2 == 0) ? 64'd2 : 64'd7);
        end
        bus.req_valid = 2'b00;
        step();
        chk("t3_drain", 64'(bus.rsp_valid), 64'd0);

        // Back-pressure: slot held, no grants, release grants in the same cycle.
        bus.rsp_ready = 1'b0;
        set_req(0, 64'd5, 64'd6, 1'b0);
        bus.req_valid = 2'b01;
        step();
        set_req(1, 64'd100, 64'd1, 1'b0);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            chk("t4_rdy", 64'(bus.req_ready), 64'd0);
            chk("t4_res", bus.rsp_result, 64'd11);
            chk("t4_id",  64'(bus.rsp_id), 64'd0);
            chk("t4_vld", 64'(bus.rsp_valid), 64'd1);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("t4_rel_rdy", 64'(bus.req_ready), 64'd2);
        step();
        bus.req_valid = 2'b00;
        chk("t4_rel_res", bus.rsp_result, 64'd101);
        chk("t4_rel_id",  64'(bus.rsp_id), 64'd1);
        step();
        chk("t4_empty", 64'(bus.rsp_valid), 64'd0);

        // Async reset while FULL with pointer at 1 and nonzero counter.
        bus.rsp_ready = 1'b0;
        set_req(0, 64'd7, 64'd8, 1'b0);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        chk("t5_full", 64'(bus.rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_vld", 64'(bus.rsp_valid), 64'd0);
        chk("t5_cnt", 64'(bus.of_count), 64'd0);
        chk("t5_res", bus.rsp_result, 64'd0);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(1, 64'd3, 64'd4, 1'b0);
        bus.req_valid = 2'b11;
        #1;
        chk("t5_ptr", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 2'b00;
        chk("t5_id", 64'(bus.rsp_id), 64'd0);
        chk("t5_first", bus.rsp_result, 64'd15);
        step();

        // Saturation of the overflow counter at all-ones (15 for 4 bits).
        set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        bus.req_valid = 2'b01;
        for (int k = 0; k < 17; k++) begin
            step();
            chk("t6_cnt", 64'(bus.of_count), (k + 1 < 15) ? 64'(k + 1) : 64'd15);
        end
        set_req(0, 64'd1, 64'd1, 1'b0);
        step();
        bus.req_valid = 2'b00;
        chk("t6_hold", 64'(bus.of_count), 64'd15);
        chk("t6_of0",  64'(bus.rsp_of), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
